// File: rtl/interrupt_pending_unit.sv
// Interrupt pending unit: synchronised level/edge requests, lowest-index priority select; overrun flags with INTERRUPT_PENDING_OVERRUN_EN.
// Latency: input to pendingLines SYNC_STAGES+1 edges, to interruptActive/index +1 more; no backpressure, ack/clear act next edge.
module interrupt_pending_unit #(
  parameter int LINE_COUNT  = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LINE_COUNT-1:0]  externalInterruptLines,
  input  logic [LINE_COUNT-1:0]  edgeModeMask,
  input  logic [LINE_COUNT-1:0]  pswInterruptMask,
  input  logic                   pswInterruptEnable,
  input  logic                   acknowledgeEnable,
  input  logic [INDEX_WIDTH-1:0] acknowledgeIndex,
  input  logic [LINE_COUNT-1:0]  clearMask,
  output logic [LINE_COUNT-1:0]  pendingLines,
  output logic                   interruptActive,
  output logic [INDEX_WIDTH-1:0] index,
  output logic [LINE_COUNT-1:0]  overrunLines
);

  logic [LINE_COUNT-1:0]  sync_q [SYNC_STAGES];
  logic [LINE_COUNT-1:0]  prev;
  logic [LINE_COUNT-1:0]  synced;
  logic [LINE_COUNT-1:0]  rise;
  logic [LINE_COUNT-1:0]  clr;
  logic [LINE_COUNT-1:0]  pending_next;
  logic [LINE_COUNT-1:0]  masked;
  logic [INDEX_WIDTH-1:0] sel_idx;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev;
  assign masked = pendingLines & pswInterruptMask;

  // Out-of-range acknowledge indices match no line and so clear nothing.
  always_comb begin
    clr = clearMask;
    for (int i = 0; i < LINE_COUNT; i++) begin
      if (acknowledgeEnable && int'(acknowledgeIndex) == i) clr[i] = 1'b1;
    end
  end

  // A rise wins over a same-cycle clear so a fresh edge is never dropped.
  always_comb begin
    pending_next = '0;
    for (int i = 0; i < LINE_COUNT; i++) begin
      if (edgeModeMask[i]) pending_next[i] = rise[i] | (pendingLines[i] & ~clr[i]);
      else                 pending_next[i] = synced[i];
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = LINE_COUNT - 1; i >= 0; i--) begin
      if (masked[i]) sel_idx = INDEX_WIDTH'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev            <= '0;
      pendingLines    <= '0;
      interruptActive <= 1'b0;
      index           <= '0;
    end else begin
      sync_q[0] <= externalInterruptLines;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev            <= synced;
      pendingLines    <= pending_next;
      interruptActive <= (|masked) & pswInterruptEnable;
      index           <= sel_idx;
    end
  end

`ifdef INTERRUPT_PENDING_OVERRUN_EN
  logic [LINE_COUNT-1:0] overrun_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= (overrun_q & ~clearMask) |
                   (edgeModeMask & rise & pendingLines & ~clr);
    end
  end

  assign overrunLines = overrun_q;
`else
  assign overrunLines = '0;
`endif

endmodule

// File: tb/tb_interrupt_pending_unit.sv
// Randomised scoreboard bench for interrupt_pending_unit: a 16-line and an 8-line instance share stimulus.
module tb_interrupt_pending_unit;

  localparam int SYNC_STAGES = 2;

  logic        clock;
  logic        reset;
  logic [15:0] ext_lines;
  logic [15:0] edge_mode;
  logic [15:0] psw_mask;
  logic        ien;
  logic        ack_en;
  logic [3:0]  ack_idx;
  logic [15:0] clr_mask;

  logic [15:0] pend16;
  logic        act16;
  logic [3:0]  idx16;
  logic [15:0] ovr16;
  logic [7:0]  pend8;
  logic        act8;
  logic [3:0]  idx8;
  logic [7:0]  ovr8;

  interrupt_pending_unit #(.LINE_COUNT(16), .INDEX_WIDTH(4), .SYNC_STAGES(SYNC_STAGES)) dut16 (
    .clock(clock), .reset(reset),
    .externalInterruptLines(ext_lines), .edgeModeMask(edge_mode),
    .pswInterruptMask(psw_mask), .pswInterruptEnable(ien),
    .acknowledgeEnable(ack_en), .acknowledgeIndex(ack_idx), .clearMask(clr_mask),
    .pendingLines(pend16), .interruptActive(act16), .index(idx16), .overrunLines(ovr16)
  );

  interrupt_pending_unit #(.LINE_COUNT(8), .INDEX_WIDTH(4), .SYNC_STAGES(SYNC_STAGES)) dut8 (
    .clock(clock), .reset(reset),
    .externalInterruptLines(ext_lines[7:0]), .edgeModeMask(edge_mode[7:0]),
    .pswInterruptMask(psw_mask[7:0]), .pswInterruptEnable(ien),
    .acknowledgeEnable(ack_en), .acknowledgeIndex(ack_idx), .clearMask(clr_mask[7:0]),
    .pendingLines(pend8), .interruptActive(act8), .index(idx8), .overrunLines(ovr8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pend;
    logic        act;
    logic [3:0]  idx;
    logic [31:0] ovr;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  int checks = 0;
  int fails  = 0;

  // Reference model state: what a line "is", seen through the synchroniser delay.
  int          line_count [2] = '{16, 8};
  logic [31:0] m_hist [2][SYNC_STAGES];
  logic [31:0] m_prev [2];
  logic [31:0] m_pend [2];
  logic [31:0] m_ovr  [2];
  logic        m_act  [2];
  logic [3:0]  m_idx  [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, want);
    end
  endtask

  task automatic model_step(input int k);
    logic [31:0] vm, s, rise, clr, msk, low;
    exp_t e;
    vm = (32'd1 << line_count[k]) - 32'd1;
    if (reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) m_hist[k][j] = '0;
      m_prev[k] = '0; m_pend[k] = '0; m_ovr[k] = '0; m_act[k] = 1'b0; m_idx[k] = '0;
    end else begin
      s    = m_hist[k][SYNC_STAGES-1];
      rise = s & ~m_prev[k];
      clr  = {16'd0, clr_mask} & vm;
      if (ack_en && int'(ack_idx) < line_count[k]) clr = clr | (32'd1 << ack_idx);
      msk  = m_pend[k] & {16'd0, psw_mask} & vm;
      low  = msk & (~msk + 32'd1);
      m_idx[k] = (msk == 0) ? 4'd0 : 4'($clog2(low));
      m_act[k] = (msk != 0) && ien;
`ifdef INTERRUPT_PENDING_OVERRUN_EN
      m_ovr[k] = (m_ovr[k] & ~{16'd0, clr_mask}) |
                 ({16'd0, edge_mode} & vm & rise & m_pend[k] & ~clr);
`endif
      m_pend[k] = ({16'd0, edge_mode} & vm & (rise | (m_pend[k] & ~clr))) |
                  (~{16'd0, edge_mode} & vm & s);
      m_prev[k] = s;
      for (int j = SYNC_STAGES - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = {16'd0, ext_lines} & vm;
    end
    e.pend = m_pend[k]; e.act = m_act[k]; e.idx = m_idx[k]; e.ovr = m_ovr[k];
    if (k == 0) q16.push_back(e);
    else        q8.push_back(e);
  endtask

  // Inputs are already applied; record the expectation, then let one edge pass.
  task automatic cyc();
    model_step(0);
    model_step(1);
    @(negedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    if (q16.size() != 0) begin
      exp_t e;
      e = q16.pop_front();
      check("pend16", {16'd0, pend16}, e.pend);
      check("act16",  {31'd0, act16},  {31'd0, e.act});
      check("idx16",  {28'd0, idx16},  {28'd0, e.idx});
      check("ovr16",  {16'd0, ovr16},  e.ovr);
    end
    if (q8.size() != 0) begin
      exp_t e;
      e = q8.pop_front();
      check("pend8", {24'd0, pend8}, e.pend);
      check("act8",  {31'd0, act8},  {31'd0, e.act});
      check("idx8",  {28'd0, idx8},  {28'd0, e.idx});
      check("ovr8",  {24'd0, ovr8},  e.ovr);
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < SYNC_STAGES; j++) m_hist[k][j] = '0;
      m_prev[k] = '0; m_pend[k] = '0; m_ovr[k] = '0; m_act[k] = 1'b0; m_idx[k] = '0;
    end
    reset = 1'b1; ext_lines = '0; edge_mode = '0; psw_mask = 16'hFFFF; ien = 1'b1;
    ack_en = 1'b0; ack_idx = '0; clr_mask = '0;
    repeat (3) cyc();
    reset = 1'b0;

    // Edge line 5 pulsed for three cycles, then acknowledged.
    edge_mode = 16'h0024;
    ext_lines = 16'h0020;
    repeat (3) cyc();
    ext_lines = '0;
    repeat (4) cyc();
    ack_en = 1'b1; ack_idx = 4'd5;
    cyc();
    ack_en = 1'b0;
    repeat (3) cyc();

    // Level lines 3 and 9 under changing mask and IEN.
    ext_lines = 16'h0208; psw_mask = 16'hFFF7;
    repeat (5) cyc();
    psw_mask = 16'hFFFF;
    repeat (2) cyc();
    ien = 1'b0;
    repeat (2) cyc();
    ien = 1'b1; ext_lines = '0;
    repeat (4) cyc();

    // Edge line 2: second rise collides with an acknowledge, then a third rise while pending.
    ext_lines = 16'h0004;
    cyc();
    ext_lines = '0;
    repeat (4) cyc();
    ext_lines = 16'h0004;
    repeat (2) cyc();
    ack_en = 1'b1; ack_idx = 4'd2;
    cyc();
    ack_en = 1'b0; ext_lines = '0;
    repeat (2) cyc();
    ext_lines = 16'h0004;
    repeat (4) cyc();
    clr_mask = 16'h0004;
    cyc();
    clr_mask = '0;
    repeat (2) cyc();

    // Out-of-range acknowledge for the 8-line instance, then reset mid-operation.
    ext_lines = 16'h8001; edge_mode = 16'h8001;
    repeat (5) cyc();
    ack_en = 1'b1; ack_idx = 4'hF;
    cyc();
    ack_en = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (5) cyc();

    // Randomised phase; lines toggle sparsely so edges survive the synchroniser.
    edge_mode = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      ext_lines = ext_lines ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) edge_mode = edge_mode ^ (16'd1 << $urandom_range(0, 15));
      psw_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      ien      = ($urandom_range(0, 9) != 0);
      ack_en   = ($urandom_range(0, 2) == 0);
      ack_idx  = ($urandom_range(0, 1) == 0) ? m_idx[0] : 4'($urandom);
      clr_mask = ($urandom_range(0, 19) == 0) ? 16'($urandom & $urandom) : 16'd0;
      reset    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0; ack_en = 1'b0; clr_mask = '0;

    repeat (3) @(negedge clock);
    check("scoreboard16_drained", 32'(q16.size()), 32'd0);
    check("scoreboard8_drained",  32'(q8.size()),  32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_pending_unit.md
Name: interrupt_pending_unit

Overview:
- Parametrised successor to the ECO32 CPU interrupt detector; sits between the external interrupt lines and the CPU control FSM.
- Synchronises asynchronous request lines and supports a per-line choice of level- or edge-triggered mode.
- Edge-triggered requests are latched as pending until acknowledged or cleared.
- Selects the lowest-index pending, unmasked line and presents it as registered outputs gated by the PSW interrupt-enable bit.

Parameters:
LINE_COUNT, 16, number of interrupt lines (2..32)
INDEX_WIDTH, 4, width of index outputs/inputs; must satisfy 2**INDEX_WIDTH >= LINE_COUNT
SYNC_STAGES, 2, synchroniser flops per line (1..4)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
externalInterruptLines  input  LINE_COUNT  raw asynchronous request lines
edgeModeMask  input  LINE_COUNT  per line: 1 = edge-triggered, 0 = level-sensitive
pswInterruptMask  input  LINE_COUNT  PSW mask field, 1 = line enabled
pswInterruptEnable  input  1  PSW IEN bit
acknowledgeEnable  input  1  CPU accepts interrupt acknowledgeIndex this cycle
acknowledgeIndex  input  INDEX_WIDTH  line being acknowledged
clearMask  input  LINE_COUNT  software clear of pending edge lines, 1 = clear
pendingLines  output  LINE_COUNT  registered pending vector (unmasked)
interruptActive  output  1  registered: any pending & masked-in line, AND IEN
index  output  INDEX_WIDTH  registered lowest pending & masked-in index; 0 when none pending
overrunLines  output  LINE_COUNT  sticky overrun flags (see Optional Feature)

Behaviour:
- Reset, applied at a clock edge with reset=1: all synchroniser flops, edge-history flops, pendingLines, interruptActive, index and overrunLines become 0. Reset overrides every other input.
- Synchroniser: SYNC_STAGES-deep shift chain per line; `synced[i]` is the last stage.
- Edge history: `prev[i] <= synced[i]` every cycle; `rise[i] = synced[i] & ~prev[i]`.
- Clear vector: `clr[i] = clearMask[i] | (acknowledgeEnable & acknowledgeIndex == i)`. Acknowledge with acknowledgeIndex >= LINE_COUNT has no effect.
- Pending update per cycle:
  - Edge line: `pending[i] <= rise[i] | (pending[i] & ~clr[i])`. A set and a clear in the same cycle leave the line set, so the new edge is never lost.
  - Level line: `pending[i] <= synced[i]`. Acknowledge and clear are ignored for level lines.
- Mode switch: when edgeModeMask[i] changes, pending[i] keeps its current value for that cycle's update under the new mode's rule. There is no extra flush.
- Selection, from registered pendingLines & pswInterruptMask:
  - `index <=` lowest set bit position, or 0 if none.
  - `interruptActive <=` (any set) & pswInterruptEnable.
- Latency:
  - Input transition to pendingLines: SYNC_STAGES+1 rising edges.
  - Input transition to interruptActive/index: SYNC_STAGES+2 rising edges.
  - Mask, IEN, or pending change to outputs: 1 edge.
  - Acknowledge to deassertion of interruptActive (no other pending line): 2 edges.
- A line held high through reset deasserts it as 0 and then produces a rise once the chain refills. Edge lines therefore pend after reset release.
- Pulses shorter than one clock period may be missed; this is documented and not a defect.
- Wide request: edge line held high stays pending only once; it re-pends after going low then high.

Optional Feature:
- Macro: INTERRUPT_PENDING_OVERRUN_EN.
- With the macro defined:
  - `overrunLines[i]` is set when rise[i] occurs while pending[i] is already 1 and clr[i] is 0.
  - It is sticky and cleared only by clearMask[i] or reset.
  - Level lines never set overrun.
- Without the macro: overrunLines is constant 0, and no overrun flops are synthesised.

Test Plan:
- Reset then defaults (LINE_COUNT=16, SYNC_STAGES=2) -> after reset, pendingLines=0x0000, interruptActive=0, index=0; overrunLines=0.
- Edge line 5, mask 0xFFFF, IEN=1; pulse line 5 high for 3 cycles -> pendingLines=0x0020 after 3 edges, interruptActive=1 and index=5 after 4 edges. Pending stays set after the line drops. acknowledgeEnable=1 with acknowledgeIndex=5 -> interruptActive=0 two edges later.
- Level lines 3 and 9 high, mask 0xFFF7 -> index=9. Mask set to 0xFFFF -> index=3 one edge later. IEN=0 -> interruptActive=0 next edge while pendingLines=0x0208.
- Edge line 2: a new rise arrives in the same cycle as an acknowledge of index 2 -> pending[2] remains 1. With INTERRUPT_PENDING_OVERRUN_EN, a second rise while pending sets overrunLines=0x0004, and clearMask=0x0004 clears both.
- Reset asserted mid-operation with pendingLines=0x8001 -> all outputs 0 on the reset edge. Inputs held high resume pending after SYNC_STAGES+1 edges from reset release.
- acknowledgeIndex=0xF with LINE_COUNT=8, INDEX_WIDTH=4 -> no state change.
